// File: rtl/mux_arbiter.sv
// Round-robin arbiter producing a registered one-hot mux select with a
// per-grant hold limit, a done/abandon release and one idle cycle between grants.
module mux_arbiter #(
  parameter int unsigned REQ_NUM  = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_NUM-1:0]         req,
  input  logic                       done,
  output logic [REQ_NUM-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(REQ_NUM)-1:0] grant_id,
  output logic                       timeout
);

  localparam int unsigned ID_W = $clog2(REQ_NUM);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_n;
  logic [REQ_NUM-1:0] grant_n;
  logic [ID_W-1:0]   id_n;
  logic [ID_W-1:0]   last_id, last_n;
  logic [7:0]        hold, hold_n;
  logic              timeout_n;
  logic              found;
  logic [ID_W-1:0]   pick;
  logic              at_max;
  logic              owner_req;

  // Search starts one past the previous winner, so the last winner ranks lowest.
  always_comb begin : arb_pick
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= REQ_NUM; k++) begin
      idx = (int'(last_id) + k) % REQ_NUM;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign at_max    = (hold == 8'(MAX_HOLD));
  assign owner_req = req[grant_id];

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    id_n      = grant_id;
    last_n    = last_id;
    hold_n    = hold;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          grant_n = REQ_NUM'(1) << pick;
          id_n    = pick;
          last_n  = pick;
          hold_n  = '0;
        end
      end
      BUSY: begin
        if (done || !owner_req || at_max) begin
          state_n   = IDLE;
          grant_n   = '0;
          id_n      = '0;
          // done wins over the hold limit; an abandon never counts as a timeout
          timeout_n = !done && owner_req && at_max;
        end else if (!at_max) begin
          hold_n = hold + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        id_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      last_id  <= ID_W'(REQ_NUM - 1);
      hold     <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= id_n;
      last_id  <= last_n;
      hold     <= hold_n;
      timeout  <= timeout_n;
    end
  end

  assign grant_valid = (state == BUSY);

endmodule
